interval_timer_ctrl: RTL and testbench
======================================

// Module: interval_timer_ctrl
// PURPOSE
//  Sequencer for the centisecond tick path: owns a mod-PRESCALE prescaler and a
//  programmable interval counter, and sequences them through start/hold/stop.
//  Emits a 1-cycle TICK every PRESCALE clocks while running and a 1-cycle EXPIRE
//  after PERIOD ticks. One-shot or periodic. Feeds stopwatch/display timing logic.
// PARAMETERS
//  PRESCALE  100  clocks per TICK; legal range >= 2; prescaler width $clog2(PRESCALE)
//  CNT_W     16   width of PERIOD/REMAIN; max interval (2^CNT_W-1) ticks
// PORTS
//  CLOCK    in   1      system clock, all state on posedge
//  RESET_N  in   1      asynchronous, active-low reset
//  START    in   1      pulse: latch PERIOD and MODE, (re)start interval
//  STOP     in   1      pulse: abort, return to IDLE
//  HOLD     in   1      level: freeze prescaler and interval count while high
//  MODE     in   1      0 = one-shot, 1 = periodic; sampled only on accepted START
//  PERIOD   in   CNT_W  ticks per interval; sampled only on accepted START
//  TICK     out  1      registered 1-cycle pulse per PRESCALE running clocks
//  EXPIRE   out  1      registered 1-cycle pulse on final tick of an interval
//  BUSY     out  1      high in RUN or PAUSE
//  REMAIN   out  CNT_W  ticks left in current interval
//  IRQ      out  1      sticky expire flag (IRQ_STICKY_EN only)
//  IRQ_CLR  in   1      clears IRQ (IRQ_STICKY_EN only)
// BEHAVIOUR
//  - Reset (RESET_N low, async): state IDLE; prescaler 0; TICK, EXPIRE, BUSY,
//    REMAIN, IRQ all 0; latched period/mode 0. Reset mid-interval discards it.
//  - FSM states IDLE, RUN, PAUSE. Input priority per cycle: STOP > START > HOLD.
//  - IDLE: START with PERIOD!=0 -> RUN next edge, REMAIN=PERIOD, prescaler=0.
//    START with PERIOD==0 ignored (stay IDLE, no pulses).
//  - RUN: prescaler counts 0..PRESCALE-1 and wraps. On the edge where it wraps:
//    TICK=1 and REMAIN decrements. First TICK exactly PRESCALE clocks after entry.
//  - Terminal: wrap with REMAIN==1 -> TICK=1 and EXPIRE=1 on same edge.
//    periodic: REMAIN reloads latched period, stays RUN, no gap (interval =
//    PERIOD*PRESCALE clocks exactly). one-shot: REMAIN=0, state IDLE, BUSY=0.
//  - RUN with HOLD=1 -> PAUSE; prescaler and REMAIN frozen, no TICK.
//    PAUSE with HOLD=0 -> RUN, resuming from frozen prescaler value.
//  - START while BUSY: restart (reload PERIOD/MODE, prescaler=0) -> RUN; if HOLD
//    still high, PAUSE on following edge. START with PERIOD==0 while BUSY acts
//    as STOP.
//  - STOP in any state -> IDLE, REMAIN=0, prescaler=0, no TICK/EXPIRE that edge.
//    STOP in IDLE: no effect. STOP+START same cycle: STOP wins.
//  - TICK/EXPIRE never asserted outside RUN; never longer than one cycle.
// CONFIGURATION
//  IRQ_STICKY_EN defined: IRQ set on any EXPIRE edge, held until IRQ_CLR; EXPIRE
//    and IRQ_CLR same cycle -> IRQ stays 1 (set wins). Unaffected by STOP.
//  IRQ_STICKY_EN undefined: IRQ and IRQ_CLR ports absent; EXPIRE is the only
//    completion indication.
// STRUCTURE
//  - timer_pkg: FSM state encoding localparams (IDLE/RUN/PAUSE), MODE encodings
//    (MODE_ONESHOT=0, MODE_PERIODIC=1).
//  - Sub-module tick_prescaler: mod-PRESCALE counter with enable and sync clear,
//    registered wrap pulse; top holds FSM, interval counter, latched config.
// TESTING
//  1 PRESCALE=100, PERIOD=3, MODE=0, START -> TICK at +100,+200,+300 clocks;
//    EXPIRE with 3rd TICK; BUSY low and REMAIN=0 same edge.
//  2 PERIOD=2, MODE=1 -> EXPIRE every 200 clocks for 5 intervals, zero drift;
//    REMAIN sequence 2,1,2,1...
//  3 HOLD high for 37 clocks at prescaler=50 -> next TICK delayed exactly 37.
//  4 STOP and START same cycle mid-run -> IDLE, no TICK/EXPIRE; START PERIOD=0
//    in IDLE -> stays IDLE, BUSY=0.
//  5 RESET_N low mid-interval (async, between edges) -> all outputs 0 at once;
//    new START after release behaves as case 1.
//  6 IRQ_STICKY_EN: EXPIRE sets IRQ; holds through STOP; IRQ_CLR clears;
//    EXPIRE+IRQ_CLR coincident -> IRQ remains 1.

Source files
------------

// File: rtl/interval_timer_ctrl_pkg.sv
// ============================================================================
//  Module      : interval_timer_ctrl_pkg
//  Description : Shared FSM state and MODE encodings for the interval timer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package interval_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/interval_timer_ctrl_tick_prescaler.sv
// ============================================================================
//  Module      : interval_timer_ctrl_tick_prescaler
//  Description : Mod-PRESCALE counter with enable, sync clear, registered tick.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module interval_timer_ctrl_tick_prescaler #(
    parameter int PRESCALE = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap,
    output logic o_tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] c_last = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          w_wrap;

    // Combinational wrap lets the owner update its interval count on the same edge.
    assign w_wrap = i_en && !i_clr && (cnt_q == c_last);

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d  = w_wrap ? '0 : cnt_q + 1'b1;
            tick_d = w_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_wrap = w_wrap;
    assign o_tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/interval_timer_ctrl.sv
// ============================================================================
//  Module      : interval_timer_ctrl
//  Description : Start/hold/stop sequencer for a prescaled interval timer.
//                Optional sticky IRQ when IRQ_STICKY_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module interval_timer_ctrl
    import interval_timer_ctrl_pkg::*;
#(
    parameter int PRESCALE = 100,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_hold,
    input  logic             i_mode,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_tick,
    output logic             o_expire,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_remain
`ifdef IRQ_STICKY_EN
    ,
    input  logic             i_irq_clr,
    output logic             o_irq
`endif
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             expire_q, expire_d;

    logic w_busy;
    logic w_presc_en;
    logic w_presc_clr;
    logic w_wrap;

    assign w_busy = (state_q != ST_IDLE);

    // STOP and START both restart the prescaler from zero; only an uncontested,
    // unheld busy cycle advances it (a PAUSE->RUN edge counts as running).
    assign w_presc_clr = i_stop | i_start;
    assign w_presc_en  = w_busy & ~i_hold & ~i_stop & ~i_start;

    interval_timer_ctrl_tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_presc_en),
        .i_clr  (w_presc_clr),
        .o_wrap (w_wrap),
        .o_tick (o_tick)
    );

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        period_d = period_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
        if (i_stop) begin
            state_d  = ST_IDLE;
            remain_d = '0;
        end else if (i_start) begin
            if (i_period != '0) begin
                state_d  = ST_RUN;
                remain_d = i_period;
                period_d = i_period;
                mode_d   = i_mode;
            end else if (w_busy) begin
                state_d  = ST_IDLE;
                remain_d = '0;
            end
        end else if (w_busy) begin
            if (i_hold) begin
                state_d = ST_PAUSE;
            end else begin
                state_d = ST_RUN;
                if (w_wrap) begin
                    if (remain_q == c_one) begin
                        expire_d = 1'b1;
                        if (mode_q == MODE_PERIODIC) begin
                            remain_d = period_q;
                        end else begin
                            remain_d = '0;
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        remain_d = remain_q - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    assign o_expire = expire_q;
    assign o_busy   = w_busy;
    assign o_remain = remain_q;

`ifdef IRQ_STICKY_EN
    logic irq_q, irq_d;

    // Set beats clear so a coincident expire is never lost.
    always_comb begin
        irq_d = irq_q;
        if (expire_d) begin
            irq_d = 1'b1;
        end else if (i_irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign o_irq = irq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
// ============================================================================
//  Module      : tb_interval_timer_ctrl
//  Description : Directed and randomized bench with an elapsed-time reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_interval_timer_ctrl;

    localparam int P = 100;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         hold = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] period = '0;
    logic         tick;
    logic         expire;
    logic         busy;
    logic [W-1:0] remain;
`ifdef IRQ_STICKY_EN
    logic         irq_clr = 1'b0;
    logic         irq;
`endif

    always #5 clk = ~clk;

    interval_timer_ctrl #(
        .PRESCALE (P),
        .CNT_W    (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (start),
        .i_stop   (stop),
        .i_hold   (hold),
        .i_mode   (mode),
        .i_period (period),
        .o_tick   (tick),
        .o_expire (expire),
        .o_busy   (busy),
        .o_remain (remain)
`ifdef IRQ_STICKY_EN
        ,
        .i_irq_clr (irq_clr),
        .o_irq     (irq)
`endif
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: an interval is described only by the running clocks
    // elapsed since START; ticks, expiries and REMAIN follow by arithmetic.
    bit m_busy    = 1'b0;
    bit m_mode    = 1'b0;
    int m_period  = 0;
    int m_elapsed = 0;
    bit m_tick    = 1'b0;
    bit m_expire  = 1'b0;
    bit m_irq     = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_mode = 0; m_period = 0; m_elapsed = 0;
        m_tick = 0; m_expire = 0; m_irq = 0;
    endtask

    function automatic int model_remain();
        if (!m_busy) return 0;
        return m_period - ((m_elapsed / P) % m_period);
    endfunction

    task automatic model_step();
        m_tick   = 0;
        m_expire = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (stop) begin
            m_busy = 0;
            m_elapsed = 0;
        end else if (start) begin
            if (period != '0) begin
                m_busy = 1; m_mode = mode; m_period = int'(period); m_elapsed = 0;
            end else begin
                m_busy = 0;
            end
        end else if (m_busy && !hold) begin
            m_elapsed++;
            if (m_elapsed % P == 0) begin
                m_tick = 1;
                if ((m_elapsed / P) % m_period == 0) begin
                    m_expire = 1;
                    if (!m_mode) m_busy = 0;
                end
            end
        end
`ifdef IRQ_STICKY_EN
        if (m_expire) m_irq = 1;
        else if (irq_clr) m_irq = 0;
`endif
    endtask

    task automatic check_all();
        check_val("tick", 32'(tick), 32'(m_tick));
        check_val("expire", 32'(expire), 32'(m_expire));
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("remain", 32'(remain), model_remain());
`ifdef IRQ_STICKY_EN
        check_val("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_start(input int per, input bit md);
        period = W'(per);
        mode   = md;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic run_case1();
        int tick_at[$];
        int exp_at;
        exp_at = -1;
        do_start(3, 1'b0);
        for (int cyc = 1; cyc <= 310; cyc++) begin
            step();
            if (tick) tick_at.push_back(cyc);
            if (expire) exp_at = cyc;
        end
        check_val("c1_ntick", tick_at.size(), 3);
        check_val("c1_tick1", (tick_at.size() > 0) ? tick_at[0] : -1, 100);
        check_val("c1_tick2", (tick_at.size() > 1) ? tick_at[1] : -1, 200);
        check_val("c1_tick3", (tick_at.size() > 2) ? tick_at[2] : -1, 300);
        check_val("c1_expire", exp_at, 300);
        check_val("c1_idle", 32'(busy), 0);
    endtask

    initial begin
        // reset state
        step();
        step();
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_remain", 32'(remain), 0);
        rst_n = 1'b1;
        step();

        // one-shot timing
        run_case1();

        // periodic, drift-free
        begin
            int exp_at[$];
            do_start(2, 1'b1);
            for (int cyc = 1; cyc <= 1005; cyc++) begin
                step();
                if (expire) exp_at.push_back(cyc);
            end
            check_val("c2_nexp", exp_at.size(), 5);
            for (int k = 0; k < 5; k++)
                check_val("c2_exp_at", (exp_at.size() > k) ? exp_at[k] : -1, 200 * (k + 1));
            do_stop();
        end

        // hold for 37 clocks at prescaler 50
        begin
            int first_tick;
            first_tick = -1;
            do_start(5, 1'b0);
            for (int cyc = 1; cyc <= 160; cyc++) begin
                hold = (cyc > 50 && cyc <= 87);
                step();
                if (tick && first_tick < 0) first_tick = cyc;
            end
            hold = 1'b0;
            check_val("c3_tick_delay", first_tick, 137);
            do_stop();
        end

        // STOP+START together, then START with zero period in IDLE
        begin
            int n_pulses;
            n_pulses = 0;
            do_start(4, 1'b0);
            for (int cyc = 0; cyc < 150; cyc++) step();
            stop = 1'b1;
            do_start(3, 1'b1);
            stop = 1'b0;
            check_val("c4_stop_wins", 32'(busy), 0);
            for (int cyc = 0; cyc < 300; cyc++) begin
                step();
                if (tick || expire) n_pulses++;
            end
            check_val("c4_no_pulse", n_pulses, 0);
            do_start(0, 1'b0);
            check_val("c4_zero_period", 32'(busy), 0);
            for (int cyc = 0; cyc < 10; cyc++) step();
        end

        // asynchronous reset mid-interval
        begin
            do_start(3, 1'b1);
            for (int cyc = 0; cyc < 250; cyc++) step();
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            check_val("c5_busy", 32'(busy), 0);
            check_val("c5_remain", 32'(remain), 0);
            check_val("c5_tick", 32'(tick), 0);
            check_val("c5_expire", 32'(expire), 0);
`ifdef IRQ_STICKY_EN
            check_val("c5_irq", 32'(irq), 0);
`endif
            step();
            step();
            rst_n = 1'b1;
            step();
            run_case1();
        end

`ifdef IRQ_STICKY_EN
        begin
            do_start(1, 1'b0);
            for (int cyc = 0; cyc < 100; cyc++) step();
            check_val("c6_irq_set", 32'(irq), 1);
            do_stop();
            check_val("c6_irq_stop", 32'(irq), 1);
            irq_clr = 1'b1;
            step();
            irq_clr = 1'b0;
            check_val("c6_irq_clr", 32'(irq), 0);
            do_start(1, 1'b1);
            for (int cyc = 0; cyc < 99; cyc++) step();
            irq_clr = 1'b1;
            step();
            check_val("c6_coinc_exp", 32'(expire), 1);
            check_val("c6_coinc_irq", 32'(irq), 1);
            step();
            check_val("c6_clr_after", 32'(irq), 0);
            irq_clr = 1'b0;
            do_stop();
        end
`endif

        // randomized traffic
        for (int i = 0; i < 15000; i++) begin
            start = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 299) == 0);
            if (start) begin
                period = W'($urandom_range(0, 4));
                mode   = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 59) == 0) hold = ~hold;
`ifdef IRQ_STICKY_EN
            irq_clr = ($urandom_range(0, 15) == 0);
`endif
            step();
        end
        start = 1'b0;
        stop  = 1'b0;
        hold  = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
